// File: rtl/scoreboard_ctrl.sv
// Sequencing controller for the in-order-commit scoreboard: tags and pushes decoded
// instructions, round-robin arbitrates FU completions onto the finish port, and
// runs the commit/flush state machine.
module scoreboard_ctrl #(
  parameter int unsigned NUM_FU       = 4,
  parameter int unsigned TAG_W        = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  // decode side
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic [4:0]              dec_rd,
  input  logic [4:0]              dec_rs1,
  input  logic [4:0]              dec_rs2,
  output logic [TAG_W-1:0]        dec_tag,
  // functional-unit completions
  input  logic [NUM_FU-1:0]       fu_done,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  output logic [NUM_FU-1:0]       fu_ack,
  // flush
  input  logic                    flush_req,
  input  logic [TAG_W-1:0]        flush_tag,
  // retire
  output logic                    commit_valid,
  output logic [TAG_W-1:0]        commit_tag,
  // scoreboard side
  output logic                    sb_push,
  output logic [31:0]             sb_instr_in,
  output logic [4:0]              sb_rd,
  output logic [4:0]              sb_rs1,
  output logic [4:0]              sb_rs2,
  output logic [31:0]             sb_instr_to_finish,
  output logic                    sb_start_head,
  output logic                    sb_committing,
  output logic                    sb_flushing,
  output logic [31:0]             sb_instr_to_flush,
  input  logic                    sb_full,
  input  logic                    sb_empty,
  input  logic [31:0]             sb_head_instr,
  input  logic                    sb_head_ready
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [TAG_W-1:0] TAG_MAX = '1;
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;

  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand;
  logic [TAG_W-1:0]  grant_tag;

  // Only the low TAG_W bits of the head entry carry a tag.
  logic unused_head_bits;
  assign unused_head_bits = ^sb_head_instr;

  // Round-robin search: first requesting FU at or after the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      cand = PTR_W'((32'(rr_q) + i) % NUM_FU);
      if (!grant_any && fu_done[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    grant_tag = fu_tag[32'(grant_idx)*TAG_W +: TAG_W];
  end

  // Next-state and output decode; flush_req overrides every other transition.
  always_comb begin
    state_d            = state_q;
    tag_d              = tag_q;
    rr_d               = rr_q;
    fcnt_d             = fcnt_q;
    dec_ready          = 1'b0;
    dec_tag            = '0;
    fu_ack             = '0;
    commit_valid       = 1'b0;
    commit_tag         = '0;
    sb_push            = 1'b0;
    sb_instr_in        = '0;
    sb_rd              = '0;
    sb_rs1             = '0;
    sb_rs2             = '0;
    sb_instr_to_finish = '0;
    sb_start_head      = 1'b0;
    sb_committing      = 1'b0;
    sb_flushing        = 1'b0;
    sb_instr_to_flush  = '0;

    if (!reset) begin
      // dispatch
      dec_ready   = !sb_full && (state_q != S_FLUSH) && !flush_req;
      dec_tag     = tag_q;
      sb_instr_in = 32'(tag_q);
      sb_rd       = dec_rd;
      sb_rs1      = dec_rs1;
      sb_rs2      = dec_rs2;
      sb_push     = dec_valid && dec_ready;
      if (sb_push) begin
        tag_d = (tag_q == TAG_MAX) ? TAG_ONE : tag_q + TAG_ONE;
      end

      // completion arbitration; a zero tag is acked but not forwarded
      if (grant_any && (state_q != S_FLUSH) && !flush_req) begin
        fu_ack             = NUM_FU'(1) << grant_idx;
        sb_instr_to_finish = 32'(grant_tag);
        rr_d = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : PTR_W'(grant_idx + PTR_W'(1));
      end

      // commit / flush sequencing
      if (flush_req) begin
        sb_flushing       = 1'b1;
        sb_instr_to_flush = 32'(flush_tag);
        tag_d             = (flush_tag == '0) ? TAG_ONE : flush_tag;
        fcnt_d            = '0;
        state_d           = S_FLUSH;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!sb_empty) state_d = S_START;
          end
          S_START: begin
            sb_start_head = 1'b1;
            state_d       = S_WAIT;
          end
          S_WAIT: begin
            if (sb_head_ready) state_d = S_COMMIT;
          end
          S_COMMIT: begin
            sb_committing = 1'b1;
            commit_valid  = 1'b1;
            commit_tag    = sb_head_instr[TAG_W-1:0];
            state_d       = S_IDLE;
          end
          S_FLUSH: begin
            if (fcnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
              state_d = S_IDLE;
            end else begin
              fcnt_d = fcnt_q + CNT_W'(1);
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      tag_q   <= TAG_ONE;
      rr_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      rr_q    <= rr_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Self-checking bench for scoreboard_ctrl: directed scenarios plus a randomized
// dispatch/arbitration/flush run against a behavioural model.
module tb_scoreboard_ctrl;

  localparam int unsigned NUM_FU       = 4;
  localparam int unsigned TAG_W        = 8;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned TAG_WS       = 3;

  logic                    clock;
  logic                    reset;
  logic                    dec_valid;
  logic [4:0]              dec_rd, dec_rs1, dec_rs2;
  logic [NUM_FU-1:0]       fu_done;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic                    flush_req;
  logic [TAG_W-1:0]        flush_tag;
  logic                    sb_full, sb_empty, sb_head_ready;
  logic [31:0]             sb_head_instr;

  logic                    dec_ready, commit_valid, sb_push;
  logic [TAG_W-1:0]        dec_tag, commit_tag;
  logic [NUM_FU-1:0]       fu_ack;
  logic [31:0]             sb_instr_in, sb_instr_to_finish, sb_instr_to_flush;
  logic [4:0]              sb_rd, sb_rs1, sb_rs2;
  logic                    sb_start_head, sb_committing, sb_flushing;

  // narrow-tag instance for the wrap boundary
  logic [NUM_FU*TAG_WS-1:0] s_fu_tag;
  logic [TAG_WS-1:0]        s_flush_tag;
  logic                     s_dec_ready, s_commit_valid, s_sb_push;
  logic [TAG_WS-1:0]        s_dec_tag, s_commit_tag;
  logic [NUM_FU-1:0]        s_fu_ack;
  logic [31:0]              s_instr_in, s_to_finish, s_to_flush;
  logic [4:0]               s_rd, s_rs1, s_rs2;
  logic                     s_start_head, s_committing, s_flushing;

  int checks   = 0;
  int failures = 0;

  assign s_flush_tag = flush_tag[TAG_WS-1:0];

  scoreboard_ctrl #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .FLUSH_CYCLES(FLUSH_CYCLES)) u_dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_tag(dec_tag),
    .fu_done(fu_done), .fu_tag(fu_tag), .fu_ack(fu_ack),
    .flush_req(flush_req), .flush_tag(flush_tag),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .sb_push(sb_push), .sb_instr_in(sb_instr_in),
    .sb_rd(sb_rd), .sb_rs1(sb_rs1), .sb_rs2(sb_rs2),
    .sb_instr_to_finish(sb_instr_to_finish), .sb_start_head(sb_start_head),
    .sb_committing(sb_committing), .sb_flushing(sb_flushing),
    .sb_instr_to_flush(sb_instr_to_flush),
    .sb_full(sb_full), .sb_empty(sb_empty),
    .sb_head_instr(sb_head_instr), .sb_head_ready(sb_head_ready)
  );

  scoreboard_ctrl #(.NUM_FU(NUM_FU), .TAG_W(TAG_WS), .FLUSH_CYCLES(FLUSH_CYCLES)) u_small (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(s_dec_ready),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_tag(s_dec_tag),
    .fu_done(fu_done), .fu_tag(s_fu_tag), .fu_ack(s_fu_ack),
    .flush_req(flush_req), .flush_tag(s_flush_tag),
    .commit_valid(s_commit_valid), .commit_tag(s_commit_tag),
    .sb_push(s_sb_push), .sb_instr_in(s_instr_in),
    .sb_rd(s_rd), .sb_rs1(s_rs1), .sb_rs2(s_rs2),
    .sb_instr_to_finish(s_to_finish), .sb_start_head(s_start_head),
    .sb_committing(s_committing), .sb_flushing(s_flushing),
    .sb_instr_to_flush(s_to_flush),
    .sb_full(sb_full), .sb_empty(sb_empty),
    .sb_head_instr(sb_head_instr), .sb_head_ready(sb_head_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    dec_valid     = 1'b0;
    dec_rd        = 5'($urandom);
    dec_rs1       = 5'($urandom);
    dec_rs2       = 5'($urandom);
    fu_done       = '0;
    fu_tag        = '0;
    s_fu_tag      = '0;
    flush_req     = 1'b0;
    flush_tag     = '0;
    sb_full       = 1'b0;
    sb_empty      = 1'b1;
    sb_head_ready = 1'b0;
    sb_head_instr = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Outputs are all zero while reset is held, then idle with tag 1.
  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    dec_valid = 1'b1; fu_done = '1; fu_tag = {4{8'h33}}; flush_req = 1'b1;
    flush_tag = 8'h09; sb_empty = 1'b0; sb_head_ready = 1'b1; sb_head_instr = 32'h55;
    #1;
    checks++;
    if ({dec_ready, sb_push, fu_ack, sb_flushing, sb_start_head, sb_committing, commit_valid} !== '0)
      begin failures++; $display("FAIL reset_ctl got=%b exp=0", {dec_ready, sb_push, fu_ack,
        sb_flushing, sb_start_head, sb_committing, commit_valid}); end
    checks++;
    if ({sb_instr_in, sb_instr_to_finish, sb_instr_to_flush, dec_tag, commit_tag} !== '0)
      begin failures++; $display("FAIL reset_data got=%h exp=0", {sb_instr_in,
        sb_instr_to_finish, sb_instr_to_flush, dec_tag, commit_tag}); end
    @(posedge clock);
    #1 reset = 1'b0;
    idle_inputs();
    @(negedge clock); #1;
    checks++;
    if (dec_tag !== 8'd1) begin failures++; $display("FAIL reset_tag got=%0d exp=1", dec_tag); end
    checks++;
    if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", dec_ready); end
    checks++;
    if ({fu_ack, sb_start_head, commit_valid, sb_flushing} !== '0)
      begin failures++; $display("FAIL reset_idle got=%b exp=0",
        {fu_ack, sb_start_head, commit_valid, sb_flushing}); end
  endtask

  // Three back-to-back pushes take tags 1,2,3.
  task automatic test_dispatch();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      dec_valid = (i < 3);
      dec_rd = 5'($urandom); dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom);
      #1;
      checks++;
      if (sb_push !== (i < 3)) begin failures++; $display("FAIL disp_push i=%0d got=%b exp=%b", i, sb_push, (i < 3)); end
      checks++;
      if (dec_tag !== 8'(i + 1)) begin failures++; $display("FAIL disp_tag i=%0d got=%0d exp=%0d", i, dec_tag, i + 1); end
      checks++;
      if (sb_instr_in !== 32'(i + 1)) begin failures++; $display("FAIL disp_instr i=%0d got=%0d exp=%0d", i, sb_instr_in, i + 1); end
      checks++;
      if ({sb_rd, sb_rs1, sb_rs2} !== {dec_rd, dec_rs1, dec_rs2})
        begin failures++; $display("FAIL disp_regs i=%0d got=%h exp=%h", i, {sb_rd, sb_rs1, sb_rs2}, {dec_rd, dec_rs1, dec_rs2}); end
    end
  endtask

  // All FUs requesting: grants rotate 0,1,2,3,0; zero tag is acked but dropped.
  task automatic test_arb_rr();
    do_reset();
    @(negedge clock);
    fu_done = 4'b1111;
    fu_tag  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      checks++;
      if (fu_ack !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_ack k=%0d got=%b exp=%b", k, fu_ack, 4'(1 << (k % 4))); end
      checks++;
      if (sb_instr_to_finish !== 32'(8'h10 + k % 4)) begin failures++; $display("FAIL rr_fin k=%0d got=%h exp=%h", k, sb_instr_to_finish, 32'(8'h10 + k % 4)); end
    end
    // pointer now at FU1
    @(negedge clock);
    fu_done = 4'b0101;
    fu_tag  = {8'h13, 8'h12, 8'h11, 8'h00};
    #1;
    checks++;
    if ({fu_ack, sb_instr_to_finish} !== {4'b0100, 32'h12}) begin failures++; $display("FAIL rr_skip got=%b/%h exp=0100/12", fu_ack, sb_instr_to_finish); end
    @(negedge clock);
    fu_done = 4'b0001;
    #1;
    checks++;
    if ({fu_ack, sb_instr_to_finish} !== {4'b0001, 32'h0}) begin failures++; $display("FAIL rr_zero_tag got=%b/%h exp=0001/0", fu_ack, sb_instr_to_finish); end
  endtask

  // IDLE -> START -> WAIT(d+1 cycles) -> COMMIT -> IDLE with varied head latency.
  task automatic test_commit();
    int d;
    logic [31:0] head;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      d    = (t == 0) ? 1 : int'($urandom_range(0, 3));
      head = $urandom;
      for (int c = 0; c <= d + 5; c++) begin
        @(negedge clock);
        sb_empty      = (c >= d + 3);
        sb_head_ready = (c == d + 2);
        sb_head_instr = head;
        #1;
        checks++;
        if (sb_start_head !== (c == 1)) begin failures++; $display("FAIL commit_start t=%0d c=%0d got=%b exp=%b", t, c, sb_start_head, (c == 1)); end
        checks++;
        if ({commit_valid, sb_committing} !== {2{c == d + 3}}) begin failures++; $display("FAIL commit_pulse t=%0d c=%0d got=%b exp=%b", t, c, {commit_valid, sb_committing}, {2{c == d + 3}}); end
        checks++;
        if (commit_tag !== ((c == d + 3) ? head[7:0] : 8'h0)) begin failures++; $display("FAIL commit_tag t=%0d c=%0d got=%h exp=%h", t, c, commit_tag, (c == d + 3) ? head[7:0] : 8'h0); end
      end
    end
  endtask

  // Flush during WAIT blocks everything; repeated flush restarts the hold; tag 0 becomes 1.
  task automatic test_flush();
    int fr_t  [14] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    int ft_t  [14] = '{5, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0};
    int rdy_t [14] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    int tag_t [14] = '{0, 0, 0, 5, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      sb_empty = 1'b0;
    end
    for (int j = 0; j < 14; j++) begin
      @(negedge clock);
      sb_empty = 1'b1; sb_head_ready = 1'b1; sb_head_instr = 32'h77;
      dec_valid = 1'b1; fu_done = 4'b1111; fu_tag = {4{8'h22}};
      flush_req = (fr_t[j] != 0);
      flush_tag = 8'(ft_t[j]);
      #1;
      checks++;
      if ({sb_flushing, sb_instr_to_flush} !== {flush_req, (flush_req ? 32'(ft_t[j]) : 32'h0)})
        begin failures++; $display("FAIL flush_out j=%0d got=%b/%0d exp=%b/%0d", j, sb_flushing, sb_instr_to_flush, flush_req, ft_t[j]); end
      checks++;
      if ({dec_ready, sb_push} !== {2{rdy_t[j] != 0}}) begin failures++; $display("FAIL flush_ready j=%0d got=%b exp=%b", j, {dec_ready, sb_push}, {2{rdy_t[j] != 0}}); end
      checks++;
      if ((fu_ack != '0) !== (rdy_t[j] != 0)) begin failures++; $display("FAIL flush_ack j=%0d got=%b exp_any=%0d", j, fu_ack, rdy_t[j]); end
      checks++;
      if ({commit_valid, sb_committing, sb_start_head} !== 3'b000) begin failures++; $display("FAIL flush_commit j=%0d got=%b exp=000", j, {commit_valid, sb_committing, sb_start_head}); end
      if (rdy_t[j] != 0) begin
        checks++;
        if (dec_tag !== 8'(tag_t[j])) begin failures++; $display("FAIL flush_tag j=%0d got=%0d exp=%0d", j, dec_tag, tag_t[j]); end
      end
    end
  endtask

  // Full scoreboard holds dispatch; reset in WAIT returns to IDLE with no pulse.
  task automatic test_full_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      dec_valid = 1'b1;
      sb_full   = (c >= 1 && c <= 3);
      #1;
      checks++;
      if ({dec_ready, sb_push} !== {2{!sb_full}}) begin failures++; $display("FAIL full_ready c=%0d got=%b exp=%b", c, {dec_ready, sb_push}, {2{!sb_full}}); end
      checks++;
      if (dec_tag !== ((c == 0) ? 8'd1 : 8'd2)) begin failures++; $display("FAIL full_tag c=%0d got=%0d exp=%0d", c, dec_tag, (c == 0) ? 1 : 2); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      dec_valid = 1'b0; sb_full = 1'b0; sb_empty = 1'b0;
    end
    @(negedge clock);
    reset = 1'b1; sb_head_ready = 1'b1; sb_head_instr = 32'h3C;
    #1;
    checks++;
    if ({commit_valid, sb_committing, sb_start_head, dec_ready} !== 4'b0000) begin failures++; $display("FAIL midreset_out got=%b exp=0000", {commit_valid, sb_committing, sb_start_head, dec_ready}); end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      #1;
      checks++;
      if (sb_start_head !== (c == 1)) begin failures++; $display("FAIL midreset_start c=%0d got=%b exp=%b", c, sb_start_head, (c == 1)); end
      checks++;
      if (commit_valid !== (c == 3)) begin failures++; $display("FAIL midreset_commit c=%0d got=%b exp=%b", c, commit_valid, (c == 3)); end
    end
    checks++;
    if (dec_tag !== 8'd1) begin failures++; $display("FAIL midreset_tag got=%0d exp=1", dec_tag); end
  endtask

  // Tag counter never issues 0: 3-bit wraps 7->1, 8-bit wraps 255->1.
  task automatic test_tag_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      dec_valid = 1'b1;
      #1;
      checks++;
      if (s_dec_tag !== 3'((i % 7) + 1)) begin failures++; $display("FAIL wrap3 i=%0d got=%0d exp=%0d", i, s_dec_tag, (i % 7) + 1); end
      checks++;
      if (dec_tag !== 8'(i + 1)) begin failures++; $display("FAIL wrap8_seq i=%0d got=%0d exp=%0d", i, dec_tag, i + 1); end
    end
    @(negedge clock);
    dec_valid = 1'b0; flush_req = 1'b1; flush_tag = 8'hFE;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      flush_req = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      dec_valid = 1'b1;
      #1;
      checks++;
      if (dec_tag !== ((i == 2) ? 8'h01 : 8'(8'hFE + i))) begin failures++; $display("FAIL wrap8 i=%0d got=%h exp=%h", i, dec_tag, (i == 2) ? 8'h01 : 8'(8'hFE + i)); end
    end
  endtask

  // Random traffic against a model of tag allocation, RR grants and flush blocking.
  task automatic test_random();
    int          m_tag, m_ptr, block_left, g;
    logic        blocked, exp_ready, exp_push;
    logic [3:0]  pend;
    logic [7:0]  ptag [4];
    logic [3:0]  exp_ack;
    logic [31:0] exp_fin;
    do_reset();
    m_tag = 1; m_ptr = 0; block_left = 0; pend = '0;
    for (int i = 0; i < 4; i++) ptag[i] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          ptag[i] = ($urandom_range(0, 7) == 0) ? 8'h0 : 8'($urandom);
        end
        fu_done[i] = pend[i];
        fu_tag[i*TAG_W +: TAG_W] = ptag[i];
      end
      dec_valid = 1'($urandom_range(0, 1));
      sb_full   = ($urandom_range(0, 3) == 0);
      flush_req = ($urandom_range(0, 19) == 0);
      flush_tag = ($urandom_range(0, 7) == 0) ? 8'h0 : 8'($urandom);
      dec_rd = 5'($urandom); dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom);
      #1;
      blocked   = (block_left != 0) || flush_req;
      exp_ready = !sb_full && !blocked;
      exp_push  = dec_valid && exp_ready;
      g = -1;
      if (!blocked)
        for (int k = 0; k < 4; k++)
          if (g < 0 && pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      exp_ack = (g >= 0) ? 4'(1 << g) : 4'h0;
      exp_fin = (g >= 0) ? 32'(ptag[g]) : 32'h0;
      checks++;
      if ({dec_ready, sb_push} !== {exp_ready, exp_push}) begin failures++; $display("FAIL rand_dispatch cyc=%0d got=%b exp=%b", cyc, {dec_ready, sb_push}, {exp_ready, exp_push}); end
      checks++;
      if ({dec_tag, sb_instr_in} !== {8'(m_tag), 32'(m_tag)}) begin failures++; $display("FAIL rand_tag cyc=%0d got=%0d/%0d exp=%0d", cyc, dec_tag, sb_instr_in, m_tag); end
      checks++;
      if ({fu_ack, sb_instr_to_finish} !== {exp_ack, exp_fin}) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b/%h exp=%b/%h", cyc, fu_ack, sb_instr_to_finish, exp_ack, exp_fin); end
      checks++;
      if ({sb_flushing, sb_instr_to_flush} !== {flush_req, (flush_req ? 32'(flush_tag) : 32'h0)}) begin failures++; $display("FAIL rand_flush cyc=%0d got=%b/%h exp=%b/%h", cyc, sb_flushing, sb_instr_to_flush, flush_req, flush_tag); end
      checks++;
      if ({sb_rd, sb_rs1, sb_rs2, sb_start_head, commit_valid} !== {dec_rd, dec_rs1, dec_rs2, 2'b00}) begin failures++; $display("FAIL rand_misc cyc=%0d got=%h exp=%h", cyc, {sb_rd, sb_rs1, sb_rs2, sb_start_head, commit_valid}, {dec_rd, dec_rs1, dec_rs2, 2'b00}); end
      if (g >= 0) begin
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % 4;
      end
      if (flush_req) begin
        m_tag      = (flush_tag == 0) ? 1 : int'(flush_tag);
        block_left = FLUSH_CYCLES;
      end else begin
        if (block_left > 0) block_left--;
        if (exp_push) m_tag = (m_tag == 255) ? 1 : m_tag + 1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_dispatch();
    test_arb_rr();
    test_commit();
    test_flush();
    test_full_reset();
    test_tag_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule
